ds_scan_ctrl: RTL and testbench

- Scan controller that sits directly upstream of the output address counter in the downsampling datapath.
- Walks a raster source image with a power-of-two decimation step and issues source read addresses to a synchronous 1-cycle-latency memory.
- Forwards each sampled pixel as a write beat, and drives the counter's clear and increment strobes so the counter supplies the destination write address.

---
 rtl/ds_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_ds_scan_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_scan_ctrl.sv
// Downsampling scan controller: walks a raster source image with a power-of-two
// step, issues reads to a 1-cycle-latency memory and forwards each sample as a write beat.
module ds_scan_ctrl #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int AW    = 32,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    factor,
    input  logic          hold,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] wr_data,
    output logic          wr_en,
    output logic          cnt_rst,
    output logic          cnt_inc,
    output logic          busy,
    output logic          done
);

    // Widths leave headroom for one step (max 8) past the image edge before the wrap test.
    localparam int CW = $clog2(IMG_W + 8) + 1;
    localparam int RW = $clog2(IMG_H + 8) + 1;
    localparam int BW = $clog2(IMG_W * (IMG_H + 8)) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   w_col_next;
    logic [CW-1:0]   w_col_step;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   w_row_next;
    logic [RW-1:0]   w_row_step;
    logic [BW-1:0]   r_row_base;
    logic [BW-1:0]   w_row_base_next;
    logic [BW-1:0]   w_row_base_inc;
    logic [BW-1:0]   w_addr;
    logic [3:0]      r_step;
    logic [3:0]      w_step_next;

    assign w_col_step     = r_col + CW'(r_step);
    assign w_row_step     = r_row + RW'(r_step);
    // Constant multiplicand: step is a power of two, so this reduces to a shift.
    assign w_row_base_inc = BW'(r_step) * BW'(IMG_W);
    assign w_addr         = r_row_base + BW'(r_col);

    // Address is only presented while reading, keeping it inside the image at all times.
    assign rd_addr = (r_state == S_READ) ? AW'(w_addr) : '0;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_step     <= 4'd1;
        end else begin
            r_state    <= w_state_next;
            r_col      <= w_col_next;
            r_row      <= w_row_next;
            r_row_base <= w_row_base_next;
            r_step     <= w_step_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_col_next      = r_col;
        w_row_next      = r_row;
        w_row_base_next = r_row_base;
        w_step_next     = r_step;
        rd_en           = 1'b0;
        wr_en           = 1'b0;
        wr_data         = '0;
        cnt_rst         = 1'b0;
        cnt_inc         = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_step_next  = 4'b0001 << factor;
                    w_state_next = S_CLR;
                end
            end

            S_CLR: begin
                busy            = 1'b1;
                cnt_rst         = 1'b1;
                w_col_next      = '0;
                w_row_next      = '0;
                w_row_base_next = '0;
                w_state_next    = S_READ;
            end

            S_READ: begin
                busy = 1'b1;
                if (!hold) begin
                    rd_en        = 1'b1;
                    w_state_next = S_WRITE;
                end
            end

            S_WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                cnt_inc = 1'b1;
                wr_data = rd_data;
                if (w_col_step < CW'(IMG_W)) begin
                    w_col_next   = w_col_step;
                    w_state_next = S_READ;
                end else begin
                    w_col_next      = '0;
                    w_row_next      = w_row_step;
                    w_row_base_next = r_row_base + w_row_base_inc;
                    w_state_next    = (w_row_step >= RW'(IMG_H)) ? S_DONE : S_READ;
                end
            end

            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ds_scan_ctrl.sv
// Bench for ds_scan_ctrl: table-driven scans, hand-written reset/disturbance sequences and
// randomized scans, all checked cycle by cycle against a sample-list timing model.
module tb_ds_scan_ctrl;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int MAXT = 300;

    logic          clock = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    factor;
    logic          hold;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          cnt_rst;
    logic          cnt_inc;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    ds_scan_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
        .clock   (clock),
        .rst     (rst),
        .start   (start),
        .factor  (factor),
        .hold    (hold),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .cnt_rst (cnt_rst),
        .cnt_inc (cnt_inc),
        .busy    (busy),
        .done    (done)
    );

    // Source memory with one cycle of read latency.
    logic [DW-1:0] mem [0:W*H-1];
    always @(posedge clock) begin
        if (rd_en && rd_addr < AW'(W*H)) rd_data <= mem[rd_addr[4:0]];
    end

    // Downstream address counter, sampling the strobes on the falling edge.
    int ext_cnt = 0;
    always @(negedge clock) begin
        if (cnt_rst)      ext_cnt <= 0;
        else if (cnt_inc) ext_cnt <= ext_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          crst;
        logic          cinc;
        logic          ren;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
    } obs_t;

    typedef struct {
        logic [1:0] f;
        int         hold_from;
        int         hold_len;
        int         exp_samples;
        int         exp_done;
        int         exp_last;
    } vec_t;

    obs_t       exp_tr     [MAXT];
    bit         hold_pat   [MAXT];
    bit         dist_start [MAXT];
    logic [1:0] dist_f     [MAXT];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic obs_t sample_obs();
        obs_t o;
        o.busy = busy;
        o.done = done;
        o.crst = cnt_rst;
        o.cinc = cnt_inc;
        o.ren  = rd_en;
        o.wen  = wr_en;
        o.addr = rd_en ? rd_addr : '0;
        o.wdat = wr_en ? wr_data : '0;
        return o;
    endfunction

    task automatic clear_pats();
        for (int i = 0; i < MAXT; i++) begin
            hold_pat[i]   = 1'b0;
            dist_start[i] = 1'b0;
            dist_f[i]     = 2'd0;
        end
    endtask

    // Reference: list the sampled pixels raster-order, then lay them on a timeline where
    // every sample costs a read cycle and a write cycle and hold only delays a pending read.
    task automatic build_expect(input int f, output int t_done, output int nsamp,
                                output int last_addr);
        int step;
        int t;
        int addrs[$];
        step = 1 << f;
        for (int i = 0; i < MAXT; i++) exp_tr[i] = '0;
        for (int r = 0; r < H; r += step)
            for (int c = 0; c < W; c += step)
                addrs.push_back(r * W + c);
        exp_tr[1].busy = 1'b1;
        exp_tr[1].crst = 1'b1;
        t = 2;
        foreach (addrs[k]) begin
            while (hold_pat[t]) begin
                exp_tr[t].busy = 1'b1;
                t++;
            end
            exp_tr[t].busy = 1'b1;
            exp_tr[t].ren  = 1'b1;
            exp_tr[t].addr = AW'(addrs[k]);
            t++;
            exp_tr[t].busy = 1'b1;
            exp_tr[t].wen  = 1'b1;
            exp_tr[t].cinc = 1'b1;
            exp_tr[t].wdat = mem[addrs[k]];
            t++;
        end
        exp_tr[t].done = 1'b1;
        t_done    = t;
        nsamp     = addrs.size();
        last_addr = addrs[addrs.size() - 1];
    endtask

    // Called at a falling edge with the DUT idle; the next rising edge takes the start.
    task automatic run_scan(input logic [1:0] f, input bit rand_dist, input bit start_at_done,
                            input string tag, output int nwr, output int done_cyc,
                            output int last_addr, output int cnt_val);
        int   t_done;
        int   ns;
        int   la;
        obs_t o;
        build_expect(int'(f), t_done, ns, la);
        if (rand_dist) begin
            for (int t = 2; t <= t_done; t++) begin
                dist_start[t] = ($urandom_range(0, 9) < 3);
                dist_f[t]     = 2'($urandom_range(0, 3));
            end
        end
        if (start_at_done) begin
            dist_start[t_done] = 1'b1;
            dist_f[t_done]     = ~f;
        end
        nwr       = 0;
        done_cyc  = 0;
        last_addr = -1;
        factor    = f;
        start     = 1'b1;
        hold      = 1'b0;
        for (int t = 1; t <= t_done + 2; t++) begin
            @(posedge clock);
            #1;
            hold  = hold_pat[t];
            start = dist_start[t];
            if (dist_start[t]) factor = dist_f[t];
            @(negedge clock);
            o = sample_obs();
            if (o.wen) nwr++;
            if (o.done && done_cyc == 0) done_cyc = t;
            if (o.ren) last_addr = int'(o.addr);
            checks++;
            if (o !== exp_tr[t]) begin
                errors++;
                $display("FAIL %s cycle %0d: got busy=%b done=%b crst=%b cinc=%b ren=%b wen=%b addr=%0d wdat=%h, want busy=%b done=%b crst=%b cinc=%b ren=%b wen=%b addr=%0d wdat=%h",
                         tag, t, o.busy, o.done, o.crst, o.cinc, o.ren, o.wen, o.addr, o.wdat,
                         exp_tr[t].busy, exp_tr[t].done, exp_tr[t].crst, exp_tr[t].cinc,
                         exp_tr[t].ren, exp_tr[t].wen, exp_tr[t].addr, exp_tr[t].wdat);
            end
        end
        start = 1'b0;
        hold  = 1'b0;
        @(posedge clock);
        #1;
        cnt_val = ext_cnt;
        @(negedge clock);
        $display("scan %s factor=%0d samples=%0d writes=%0d done_cycle=%0d counter=%0d",
                 tag, f, ns, nwr, done_cyc, cnt_val);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < W * H; i++) mem[i] = DW'($urandom_range(0, 255));
    endtask

    vec_t tbl[7];

    initial begin
        int nwr;
        int dcyc;
        int la;
        int cv;
        obs_t o;

        tbl[0] = '{2'd1, 0, 0, 8,  18, 22};
        tbl[1] = '{2'd0, 0, 0, 32, 66, 31};
        tbl[2] = '{2'd3, 0, 0, 1,  4,  0};
        tbl[3] = '{2'd2, 0, 0, 2,  6,  4};
        tbl[4] = '{2'd1, 4, 3, 8,  21, 22};
        tbl[5] = '{2'd1, 1, 1, 8,  18, 22};
        tbl[6] = '{2'd3, 2, 2, 1,  6,  0};

        rst    = 1'b1;
        start  = 1'b0;
        hold   = 1'b0;
        factor = 2'd0;
        fill_mem();
        clear_pats();
        repeat (3) @(posedge clock);
        @(negedge clock);
        o = sample_obs();
        chk("reset_outputs", int'(o), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        rst = 1'b0;
        @(negedge clock);
        chk("idle_outputs", int'(sample_obs()), 0);

        for (int i = 0; i < 7; i++) begin
            clear_pats();
            for (int t = tbl[i].hold_from; t < tbl[i].hold_from + tbl[i].hold_len; t++)
                hold_pat[t] = 1'b1;
            fill_mem();
            run_scan(tbl[i].f, 1'b0, 1'b0, $sformatf("tbl%0d", i), nwr, dcyc, la, cv);
            chk($sformatf("tbl%0d_writes", i), nwr, tbl[i].exp_samples);
            chk($sformatf("tbl%0d_done_cycle", i), dcyc, tbl[i].exp_done);
            chk($sformatf("tbl%0d_last_addr", i), la, tbl[i].exp_last);
            chk($sformatf("tbl%0d_counter", i), cv, tbl[i].exp_samples);
        end

        // Reset in the cycle of the 5th write (cycle 11), then a fresh scan.
        clear_pats();
        factor = 2'd1;
        start  = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            rst   = (t == 11);
            @(negedge clock);
            if (t == 11) chk("rst_cycle_wr_en", int'(wr_en), 1);
            if (t == 12) begin
                chk("after_rst_outputs", int'(sample_obs()), 0);
                chk("after_rst_rd_addr", int'(rd_addr), 0);
            end
        end
        @(posedge clock);
        #1;
        chk("rst_counter", ext_cnt, 5);
        @(negedge clock);
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            chk("after_rst_no_done", int'({busy, done}), 0);
        end
        fill_mem();
        run_scan(2'd1, 1'b0, 1'b0, "restart", nwr, dcyc, la, cv);
        chk("restart_done_cycle", dcyc, 18);
        chk("restart_counter", cv, 8);

        // Start and factor changes while busy, including in the DONE cycle.
        clear_pats();
        for (int t = 5; t <= 7; t++) begin
            dist_start[t] = 1'b1;
            dist_f[t]     = 2'd0;
        end
        fill_mem();
        run_scan(2'd1, 1'b0, 1'b1, "disturb", nwr, dcyc, la, cv);
        chk("disturb_done_cycle", dcyc, 18);
        chk("disturb_writes", nwr, 8);

        for (int n = 0; n < 24; n++) begin
            logic [1:0] f;
            clear_pats();
            for (int t = 1; t < 200; t++) hold_pat[t] = ($urandom_range(0, 9) < 3);
            f = 2'($urandom_range(0, 3));
            fill_mem();
            run_scan(f, 1'b1, 1'b0, $sformatf("rand%0d", n), nwr, dcyc, la, cv);
            chk($sformatf("rand%0d_counter", n), cv, ((W + (1 << f) - 1) >> f) * ((H + (1 << f) - 1) >> f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
